// File: rtl/decoder_seq.sv
// Registered one-hot decoder with level, timed-pulse and walking-sweep modes behind a
// valid/ready command port. Define DECODER_SEQ_RANGE_CHK_EN to add the err output.
module decoder_seq #(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned OUTS   = 8,
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [1:0]        in_mode,
  input  logic [HOLD_W-1:0] in_dwell,
  output logic [OUTS-1:0]   y,
  output logic              busy,
  output logic              done
`ifdef DECODER_SEQ_RANGE_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [1:0] ModeLevel = 2'b00;
  localparam logic [1:0] ModePulse = 2'b01;
  localparam logic [1:0] ModeSweep = 2'b10;
  localparam logic [1:0] ModeOff   = 2'b11;

  localparam logic [SEL_W:0]   OutsExt = (SEL_W + 1)'(OUTS);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(OUTS - 1);

  typedef enum logic [1:0] {StIdle, StHold, StPulse, StSweep} state_e;

  state_e              state_q, state_d;
  logic [OUTS-1:0]     y_q, y_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]   dwell_q, dwell_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                accept;
  logic                oob;

  function automatic logic [OUTS-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [OUTS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < OUTS; i++) begin
      if (sel == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign accept = in_valid && in_ready;
  assign oob    = ({1'b0, in_sel} >= OutsExt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (in_mode == ModeOff || oob) begin
            state_d = StIdle;
          end else begin
            case (in_mode)
              ModeLevel: state_d = StHold;
              ModePulse: state_d = StPulse;
              ModeSweep: state_d = StSweep;
              default:   state_d = StIdle;
            endcase
          end
        end
      end
      StPulse: if (cnt_q == '0) state_d = StIdle;
      StSweep: if (cnt_q == '0 && idx_q == LastIdx) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: y, dwell counter, sweep index and done strobe.
  always_comb begin
    y_d     = y_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (in_mode == ModeOff || oob) begin
            y_d = '0;
          end else begin
            y_d = onehot(in_sel);
            if (in_mode == ModePulse || in_mode == ModeSweep) begin
              cnt_d   = in_dwell;
              dwell_d = in_dwell;
            end
            if (in_mode == ModeSweep) idx_d = in_sel;
          end
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          y_d    = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      StSweep: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (idx_q == LastIdx) begin
          y_d    = '0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
          y_d   = y_q << 1;
          cnt_d = dwell_q;
        end
      end
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    busy     = (state_q == StPulse) || (state_q == StSweep);
    in_ready = !busy;
    y        = y_q;
    done     = done_q;
  end

`ifdef DECODER_SEQ_RANGE_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && (in_mode != ModeOff) && oob;
    end
  end

  assign err = err_q;
`endif

endmodule
